// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that sequences two requesters onto one shared alu_top,
// holds operands for SETTLE cycles, captures the result and returns it to the winner.
module alu_arbiter #(
  parameter int WIDTH  = 6,
  parameter int SETTLE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic [1:0]         req0_func,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  input  logic [1:0]         req1_func,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic [2*WIDTH-1:0] rsp0_out,
  output logic               rsp0_ovf,
  output logic               rsp0_err,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [2*WIDTH-1:0] rsp1_out,
  output logic               rsp1_ovf,
  output logic               rsp1_err,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [1:0]         alu_func,
  input  logic [2*WIDTH-1:0] alu_out,
  input  logic               alu_ovf
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t             state_reg;
  logic               last_reg;
  logic               id_reg;
  logic               rej_reg;
  logic [3:0]         cnt_reg;
  logic               valid_reg;
  logic [2*WIDTH-1:0] out_reg;
  logic               ovf_reg;
  logic               err_reg;
  logic [WIDTH-1:0]   alu_a_reg;
  logic [WIDTH-1:0]   alu_b_reg;
  logic [1:0]         alu_func_reg;

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0]         rsp_ready;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ovf;
  logic [1:0]         rsp_err;
  logic [2*WIDTH-1:0] rsp_out [2];

  logic               grant_id;
  logic               accept;
  logic               reject;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [1:0]         sel_func;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    localparam logic PID = (gi == 1);
    // The port that did not win last time gets the grant when both are valid.
    assign req_ready[gi] = (state_reg == IDLE) && req_valid[gi] &&
                           (!req_valid[1-gi] || (last_reg != PID));
    assign rsp_valid[gi] = valid_reg && (id_reg == PID);
    assign rsp_out[gi]   = rsp_valid[gi] ? out_reg : '0;
    assign rsp_ovf[gi]   = rsp_valid[gi] && ovf_reg;
    assign rsp_err[gi]   = rsp_valid[gi] && err_reg;
  end

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_out   = rsp_out[0];
  assign rsp1_out   = rsp_out[1];
  assign rsp0_ovf   = rsp_ovf[0];
  assign rsp1_ovf   = rsp_ovf[1];
  assign rsp0_err   = rsp_err[0];
  assign rsp1_err   = rsp_err[1];
  assign alu_a      = alu_a_reg;
  assign alu_b      = alu_b_reg;
  assign alu_func   = alu_func_reg;

  assign grant_id = req_ready[1];
  assign accept   = |req_ready;
  assign sel_a    = grant_id ? req1_a : req0_a;
  assign sel_b    = grant_id ? req1_b : req0_b;
  assign sel_func = grant_id ? req1_func : req0_func;
  // Division needs a non-negative dividend and a strictly positive divisor.
  assign reject   = (sel_func == 2'b11) &&
                    (sel_b[WIDTH-1] || (sel_b == '0) || sel_a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      last_reg     <= 1'b1;
      id_reg       <= 1'b0;
      rej_reg      <= 1'b0;
      cnt_reg      <= '0;
      valid_reg    <= 1'b0;
      out_reg      <= '0;
      ovf_reg      <= 1'b0;
      err_reg      <= 1'b0;
      alu_a_reg    <= '0;
      alu_b_reg    <= '0;
      alu_func_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            id_reg    <= grant_id;
            last_reg  <= grant_id;
            rej_reg   <= reject;
            state_reg <= ISSUE;
            // A rejected op passes through ISSUE for one cycle with the ALU inputs untouched.
            if (reject) begin
              cnt_reg <= '0;
            end else begin
              cnt_reg      <= 4'(SETTLE - 1);
              alu_a_reg    <= sel_a;
              alu_b_reg    <= sel_b;
              alu_func_reg <= sel_func;
            end
          end
        end
        ISSUE: begin
          if (cnt_reg == '0) begin
            valid_reg <= 1'b1;
            err_reg   <= rej_reg;
            out_reg   <= rej_reg ? '0 : alu_out;
            ovf_reg   <= !rej_reg && alu_ovf;
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          if (|(rsp_valid & rsp_ready)) begin
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
